// File: rtl/image_loader.sv
// Image loader: binarizes a raster of grayscale pixel beats into a flat bit
// vector and hands each completed frame to the downstream classifier.
module image_loader #(
    parameter int PIX_W     = 8,
    parameter int THRESHOLD = 128,
    parameter int NPIX      = 784
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_sof,
    output logic             img_valid,
    input  logic             img_ready,
    output logic [NPIX-1:0]  inputs,
    output logic             frame_err,
    output logic [7:0]       frame_count
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    localparam logic [9:0]       LAST_INDEX = 10'(NPIX - 1);
    localparam logic [PIX_W-1:0] THRESH     = PIX_W'(THRESHOLD);

    state_t     state;
    logic [9:0] index;
    logic       beat;
    logic       pix_bit;

    assign pix_ready = (state != HOLD);
    assign beat      = pix_valid && pix_ready;
    assign pix_bit   = (pix_data >= THRESH);

    // A start-of-frame beat always restarts the image, even in the middle of
    // a partial frame; only the last pixel of a frame moves us into HOLD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            index       <= '0;
            inputs      <= '0;
            img_valid   <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (beat) begin
                        if (pix_sof) begin
                            inputs <= {{(NPIX-1){1'b0}}, pix_bit};
                            index  <= 10'd1;
                            state  <= LOAD;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (beat) begin
                        if (pix_sof) begin
                            inputs    <= {{(NPIX-1){1'b0}}, pix_bit};
                            index     <= 10'd1;
                            frame_err <= 1'b1;
                        end else begin
                            for (int i = 0; i < NPIX; i++) begin
                                if (index == 10'(i)) begin
                                    inputs[i] <= pix_bit;
                                end
                            end
                            if (index == LAST_INDEX) begin
                                index     <= '0;
                                img_valid <= 1'b1;
                                state     <= HOLD;
                            end else begin
                                index <= index + 10'd1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (img_ready) begin
                        img_valid   <= 1'b0;
                        frame_count <= frame_count + 8'd1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// Randomized self-checking bench for image_loader against a queue-based
// frame model; a small-frame second instance exercises frame_count wrap.
module tb_image_loader;

    localparam int NPIX   = 784;
    localparam int SNPIX  = 16;
    localparam int THRESH = 128;

    logic            clk = 1'b0;
    logic            reset;
    logic            pix_valid;
    logic            pix_ready;
    logic [7:0]      pix_data;
    logic            pix_sof;
    logic            img_valid;
    logic            img_ready;
    logic [NPIX-1:0] inputs;
    logic            frame_err;
    logic [7:0]      frame_count;

    logic             s_reset;
    logic             s_pix_valid;
    logic             s_pix_ready;
    logic [7:0]       s_pix_data;
    logic             s_pix_sof;
    logic             s_img_valid;
    logic             s_img_ready;
    logic [SNPIX-1:0] s_inputs;
    logic             s_frame_err;
    logic [7:0]       s_frame_count;

    int checks = 0;
    int errors = 0;

    // Reference model: pixels of the open frame, visible image, frame counter.
    int              pix_q[$];
    bit              frame_open;
    logic [NPIX-1:0] exp_inputs;
    bit              exp_err;
    bit              exp_done;
    int              exp_count;

    always #5 clk = ~clk;

    image_loader #(.PIX_W(8), .THRESHOLD(THRESH), .NPIX(NPIX)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .img_valid  (img_valid),
        .img_ready  (img_ready),
        .inputs     (inputs),
        .frame_err  (frame_err),
        .frame_count(frame_count)
    );

    image_loader #(.PIX_W(8), .THRESHOLD(THRESH), .NPIX(SNPIX)) dut_small (
        .clk        (clk),
        .reset      (s_reset),
        .pix_valid  (s_pix_valid),
        .pix_ready  (s_pix_ready),
        .pix_data   (s_pix_data),
        .pix_sof    (s_pix_sof),
        .img_valid  (s_img_valid),
        .img_ready  (s_img_ready),
        .inputs     (s_inputs),
        .frame_err  (s_frame_err),
        .frame_count(s_frame_count)
    );

    function automatic void model_reset();
        pix_q.delete();
        frame_open = 1'b0;
        exp_inputs = '0;
        exp_err    = 1'b0;
        exp_done   = 1'b0;
        exp_count  = 0;
    endfunction

    function automatic void model_beat(input int d, input bit sof);
        exp_err  = 1'b0;
        exp_done = 1'b0;
        if (sof) begin
            exp_err    = frame_open;
            pix_q.delete();
            frame_open = 1'b1;
            exp_inputs = '0;
        end else if (!frame_open) begin
            exp_err = 1'b1;
        end
        if (frame_open) begin
            exp_inputs[pix_q.size()] = (d >= THRESH);
            pix_q.push_back(d);
            if (pix_q.size() == NPIX) begin
                exp_done   = 1'b1;
                frame_open = 1'b0;
                pix_q.delete();
            end
        end
    endfunction

    // Presents one beat from a falling edge and returns at the falling edge
    // after the rising edge that accepted it.
    task automatic send_beat(input int d, input bit sof);
        int waited;
        waited    = 0;
        pix_valid = 1'b1;
        pix_data  = 8'(d);
        pix_sof   = sof;
        while (pix_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_timeout pix_ready got %b required 1", pix_ready);
        end
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic stream(input int n, input bit first_sof, input int mode, input bit gaps);
        int d;
        bit sof;
        for (int i = 0; i < n; i++) begin
            case (mode)
                1:       d = (i % 2 == 0) ? 255 : 0;
                2:       d = (i == 0) ? 127 : (i == 1) ? 128 : (i == 2) ? 255 : int'($urandom_range(0, 255));
                default: d = int'($urandom_range(0, 255));
            endcase
            sof = first_sof && (i == 0);
            send_beat(d, sof);
            model_beat(d, sof);
            checks += 3;
            if (frame_err !== exp_err) begin
                errors++;
                $display("[TB] FAIL beat_err idx %0d got %b required %b", i, frame_err, exp_err);
            end
            if (img_valid !== exp_done) begin
                errors++;
                $display("[TB] FAIL beat_img_valid idx %0d got %b required %b", i, img_valid, exp_done);
            end
            if (inputs !== exp_inputs) begin
                errors++;
                $display("[TB] FAIL beat_inputs idx %0d got %h required %h", i, inputs, exp_inputs);
            end
            if (gaps && i != n - 1 && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    checks++;
                    if (frame_err !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL gap_err idx %0d got %b required 0", i, frame_err);
                    end
                end
            end
        end
    endtask

    task automatic complete_handshake();
        img_ready = 1'b1;
        @(negedge clk);
        exp_count = (exp_count + 1) % 256;
        checks += 4;
        if (img_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hs_img_valid got %b required 0", img_valid);
        end
        if (frame_count !== 8'(exp_count)) begin
            errors++;
            $display("[TB] FAIL hs_frame_count got %0d required %0d", frame_count, exp_count);
        end
        if (pix_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hs_pix_ready got %b required 1", pix_ready);
        end
        if (inputs !== exp_inputs) begin
            errors++;
            $display("[TB] FAIL hs_inputs_retained got %h required %h", inputs, exp_inputs);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; s_reset = 1'b0;
        pix_valid = 1'b0; pix_data = '0; pix_sof = 1'b0; img_ready = 1'b0;
        s_pix_valid = 1'b0; s_pix_data = '0; s_pix_sof = 1'b0; s_img_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        checks += 4;
        if (img_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_img_valid got %b required 0", img_valid); end
        if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_frame_err got %b required 0", frame_err); end
        if (frame_count !== 8'd0) begin errors++; $display("[TB] FAIL rst_frame_count got %0d required 0", frame_count); end
        if (inputs !== '0) begin errors++; $display("[TB] FAIL rst_inputs got %h required 0", inputs); end
        reset = 1'b1; s_reset = 1'b1;
        #1;
        checks += 2;
        if (pix_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_pix_ready got %b required 1", pix_ready); end
        if (s_pix_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_s_pix_ready got %b required 1", s_pix_ready); end
        @(negedge clk);
    endtask

    task automatic test_alternating();
        img_ready = 1'b1;
        stream(NPIX, 1'b1, 1, 1'b0);
        checks += 2;
        if (inputs !== {(NPIX/2){2'b01}}) begin
            errors++;
            $display("[TB] FAIL alt_pattern got %h required %h", inputs, {(NPIX/2){2'b01}});
        end
        if (img_valid !== 1'b1) begin errors++; $display("[TB] FAIL alt_img_valid got %b required 1", img_valid); end
        complete_handshake();
    endtask

    task automatic test_threshold();
        img_ready = 1'b1;
        stream(NPIX, 1'b1, 2, 1'b1);
        checks += 3;
        if (inputs[0] !== 1'b0) begin errors++; $display("[TB] FAIL thr_127 got %b required 0", inputs[0]); end
        if (inputs[1] !== 1'b1) begin errors++; $display("[TB] FAIL thr_128 got %b required 1", inputs[1]); end
        if (inputs[2] !== 1'b1) begin errors++; $display("[TB] FAIL thr_255 got %b required 1", inputs[2]); end
        complete_handshake();
    endtask

    task automatic test_backpressure();
        img_ready = 1'b0;
        stream(NPIX, 1'b1, 0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            pix_valid = 1'b1;
            pix_sof   = 1'($urandom_range(0, 1));
            pix_data  = 8'($urandom_range(0, 255));
            @(negedge clk);
            checks += 4;
            if (pix_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_pix_ready cyc %0d got %b required 0", c, pix_ready); end
            if (img_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_img_valid cyc %0d got %b required 1", c, img_valid); end
            if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL hold_frame_err cyc %0d got %b required 0", c, frame_err); end
            if (inputs !== exp_inputs) begin errors++; $display("[TB] FAIL hold_inputs cyc %0d got %h required %h", c, inputs, exp_inputs); end
        end
        pix_valid = 1'b0;
        complete_handshake();
    endtask

    task automatic test_idle_err();
        int d;
        img_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            d = int'($urandom_range(0, 255));
            send_beat(d, 1'b0);
            model_beat(d, 1'b0);
            checks += 4;
            if (frame_err !== exp_err) begin errors++; $display("[TB] FAIL idle_err beat %0d got %b required %b", k, frame_err, exp_err); end
            if (inputs !== exp_inputs) begin errors++; $display("[TB] FAIL idle_inputs beat %0d got %h required %h", k, inputs, exp_inputs); end
            if (img_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_img_valid beat %0d got %b required 0", k, img_valid); end
            if (pix_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_pix_ready beat %0d got %b required 1", k, pix_ready); end
            if (k % 2 == 1) @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL idle_err_clear got %b required 0", frame_err); end
    endtask

    task automatic test_mid_sof();
        img_ready = 1'b1;
        stream(300, 1'b1, 0, 1'b1);
        stream(NPIX, 1'b1, 0, 1'b1);
        checks++;
        if (img_valid !== 1'b1) begin errors++; $display("[TB] FAIL midsof_img_valid got %b required 1", img_valid); end
        complete_handshake();
    endtask

    task automatic test_reset_mid();
        img_ready = 1'b1;
        stream(500, 1'b1, 0, 1'b1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks += 5;
        if (inputs !== '0) begin errors++; $display("[TB] FAIL rmid_inputs got %h required 0", inputs); end
        if (img_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_img_valid got %b required 0", img_valid); end
        if (frame_count !== 8'd0) begin errors++; $display("[TB] FAIL rmid_frame_count got %0d required 0", frame_count); end
        if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL rmid_frame_err got %b required 0", frame_err); end
        if (pix_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_pix_ready got %b required 1", pix_ready); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (pix_ready !== 1'b1) begin errors++; $display("[TB] FAIL rel_pix_ready got %b required 1", pix_ready); end
        send_beat(255, 1'b0);
        model_beat(255, 1'b0);
        checks += 2;
        if (frame_err !== exp_err) begin errors++; $display("[TB] FAIL rel_nosof_err got %b required %b", frame_err, exp_err); end
        if (inputs !== exp_inputs) begin errors++; $display("[TB] FAIL rel_nosof_inputs got %h required %h", inputs, exp_inputs); end
        stream(NPIX, 1'b1, 0, 1'b1);
        complete_handshake();
    endtask

    task automatic test_wrap();
        logic [SNPIX-1:0] s_exp;
        int d;
        int waited;
        s_exp = '0;
        for (int f = 0; f < 256; f++) begin
            for (int p = 0; p < SNPIX; p++) begin
                d = int'($urandom_range(0, 255));
                s_exp[p]    = (d >= THRESH);
                s_pix_valid = 1'b1;
                s_pix_data  = 8'(d);
                s_pix_sof   = (p == 0);
                waited = 0;
                while (s_pix_ready !== 1'b1 && waited < 100) begin
                    @(negedge clk);
                    waited++;
                end
                if (waited >= 100) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL wrap_timeout frame %0d got %b required 1", f, s_pix_ready);
                end
                @(negedge clk);
            end
            s_pix_valid = 1'b0;
            checks += 2;
            if (s_img_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_img_valid frame %0d got %b required 1", f, s_img_valid); end
            if (s_inputs !== s_exp) begin errors++; $display("[TB] FAIL wrap_inputs frame %0d got %h required %h", f, s_inputs, s_exp); end
            @(negedge clk);
            checks++;
            if (s_frame_count !== 8'((f + 1) % 256)) begin
                errors++;
                $display("[TB] FAIL wrap_frame_count frame %0d got %0d required %0d", f, s_frame_count, (f + 1) % 256);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alternating();
        test_threshold();
        test_backpressure();
        test_idle_err();
        test_mid_sof();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
